// File: rtl/exu_muldiv_if.sv
// Bundle between the execute dispatch stage and the MULDIV unit:
// request/operands in, stall and one-cycle write-back out.
interface exu_muldiv_if;
    logic        req_muldiv_i;
    logic [31:0] muldiv_op1_i;
    logic [31:0] muldiv_op2_i;
    logic        muldiv_op_mul_i;
    logic        muldiv_op_mulh_i;
    logic        muldiv_op_mulhsu_i;
    logic        muldiv_op_mulhu_i;
    logic        muldiv_op_div_i;
    logic        muldiv_op_divu_i;
    logic        muldiv_op_rem_i;
    logic        muldiv_op_remu_i;
    logic [4:0]  rd_waddr_i;
    logic        flush_i;
    logic        muldiv_stall_o;
    logic        muldiv_reg_we_o;
    logic [4:0]  muldiv_reg_waddr_o;
    logic [31:0] muldiv_reg_wdata_o;

    modport slave (
        input  req_muldiv_i, muldiv_op1_i, muldiv_op2_i,
        input  muldiv_op_mul_i, muldiv_op_mulh_i, muldiv_op_mulhsu_i, muldiv_op_mulhu_i,
        input  muldiv_op_div_i, muldiv_op_divu_i, muldiv_op_rem_i, muldiv_op_remu_i,
        input  rd_waddr_i, flush_i,
        output muldiv_stall_o, muldiv_reg_we_o, muldiv_reg_waddr_o, muldiv_reg_wdata_o
    );

    modport master (
        output req_muldiv_i, muldiv_op1_i, muldiv_op2_i,
        output muldiv_op_mul_i, muldiv_op_mulh_i, muldiv_op_mulhsu_i, muldiv_op_mulhu_i,
        output muldiv_op_div_i, muldiv_op_divu_i, muldiv_op_rem_i, muldiv_op_remu_i,
        output rd_waddr_i, flush_i,
        input  muldiv_stall_o, muldiv_reg_we_o, muldiv_reg_waddr_o, muldiv_reg_wdata_o
    );
endinterface

// File: rtl/exu_muldiv.sv
// RV32M unit: single-cycle registered multiply, iterative restoring divide
// (one quotient bit per cycle), one-cycle write-back pulse in DONE.
module exu_muldiv #(
    parameter bit DIV_EARLY_OUT = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    exu_muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state_q, state_d;

    logic [31:0] op1, op2;
    logic        is_mul, is_sdiv, accept, op2_zero, ovf, early;
    logic [31:0] special;

    logic [31:0] a_q, b_q, quo_q, rem_q, wdata_q;
    logic [4:0]  rd_q, cnt_q, waddr_q;
    logic        sa_q, sb_q, hi_q, rem_sel_q, neg_q_q, neg_r_q, we_q;

    logic [63:0] ea, eb, prod;
    logic [31:0] mul_res, div_res, quo_nx, rem_nx;
    logic [32:0] rem_sh, rem_sub;
    logic        ge;

    assign op1      = bus.muldiv_op1_i;
    assign op2      = bus.muldiv_op2_i;
    assign is_mul   = bus.muldiv_op_mul_i | bus.muldiv_op_mulh_i |
                      bus.muldiv_op_mulhsu_i | bus.muldiv_op_mulhu_i;
    assign is_sdiv  = bus.muldiv_op_div_i | bus.muldiv_op_rem_i;
    assign accept   = (state_q == IDLE) & bus.req_muldiv_i & ~bus.flush_i;
    assign op2_zero = (op2 == 32'd0);
    assign ovf      = is_sdiv & (op1 == 32'h8000_0000) & (op2 == 32'hFFFF_FFFF);
    assign early    = DIV_EARLY_OUT & ~is_mul & (op2_zero | ovf);
    // Early-out results; quotient ops first, remainder ops second.
    assign special  = (bus.muldiv_op_div_i | bus.muldiv_op_divu_i) ?
                      (op2_zero ? 32'hFFFF_FFFF : 32'h8000_0000) :
                      (op2_zero ? op1 : 32'd0);

    // 33x33 signed product, carried in 64 bits (upper bits are never needed).
    assign ea      = {{32{sa_q & a_q[31]}}, a_q};
    assign eb      = {{32{sb_q & b_q[31]}}, b_q};
    assign prod    = ea * eb;
    assign mul_res = hi_q ? prod[63:32] : prod[31:0];

    // One restoring step; the 33-bit partial remainder covers divisors above 2^31.
    assign rem_sh  = {rem_q, a_q[5'd31 - cnt_q]};
    assign rem_sub = rem_sh - {1'b0, b_q};
    assign ge      = ~rem_sub[32];
    assign rem_nx  = ge ? rem_sub[31:0] : rem_sh[31:0];
    assign quo_nx  = {quo_q[30:0], ge};
    assign div_res = rem_sel_q ? (neg_r_q ? -rem_nx : rem_nx)
                               : (neg_q_q ? -quo_nx : quo_nx);

    // Stall and write-back are cut by flush in the same cycle.
    assign bus.muldiv_stall_o     = ((state_q == IDLE & bus.req_muldiv_i) |
                                     state_q == MUL | state_q == DIV) & ~bus.flush_i;
    assign bus.muldiv_reg_we_o    = we_q & ~bus.flush_i;
    assign bus.muldiv_reg_waddr_o = waddr_q;
    assign bus.muldiv_reg_wdata_o = wdata_q;

    // Next-state logic; flush overrides everything back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = is_mul ? MUL : (early ? DONE : DIV);
            MUL:  state_d = DONE;
            DIV:  if (cnt_q == 5'd31) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush_i) state_d = IDLE;
    end

    // State register and write-enable pulse (high exactly while in DONE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= (state_d == DONE);
        end
    end

    // Operand capture, divider iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0; b_q <= '0; quo_q <= '0; rem_q <= '0; cnt_q <= '0;
            rd_q <= '0; sa_q <= 1'b0; sb_q <= 1'b0; hi_q <= 1'b0;
            rem_sel_q <= 1'b0; neg_q_q <= 1'b0; neg_r_q <= 1'b0;
            waddr_q <= '0; wdata_q <= '0;
        end else begin
            if (accept) begin
                rd_q      <= bus.rd_waddr_i;
                cnt_q     <= '0;
                quo_q     <= '0;
                rem_q     <= '0;
                // mul sign-extension flags; division uses magnitudes instead
                sa_q      <= bus.muldiv_op_mulh_i | bus.muldiv_op_mulhsu_i;
                sb_q      <= bus.muldiv_op_mulh_i;
                hi_q      <= ~bus.muldiv_op_mul_i;
                rem_sel_q <= bus.muldiv_op_rem_i | bus.muldiv_op_remu_i;
                // no quotient sign fix on divide-by-zero: all-ones must survive
                neg_q_q   <= bus.muldiv_op_div_i & (op1[31] ^ op2[31]) & ~op2_zero;
                neg_r_q   <= bus.muldiv_op_rem_i & op1[31];
                a_q       <= (is_sdiv & op1[31]) ? -op1 : op1;
                b_q       <= (is_sdiv & op2[31]) ? -op2 : op2;
                if (is_mul) begin
                    a_q <= op1;
                    b_q <= op2;
                end
                if (early) begin
                    wdata_q <= special;
                    waddr_q <= bus.rd_waddr_i;
                end
            end
            if (state_q == MUL && !bus.flush_i) begin
                wdata_q <= mul_res;
                waddr_q <= rd_q;
            end
            if (state_q == DIV) begin
                cnt_q <= cnt_q + 5'd1;
                quo_q <= quo_nx;
                rem_q <= rem_nx;
                if (cnt_q == 5'd31 && !bus.flush_i) begin
                    wdata_q <= div_res;
                    waddr_q <= rd_q;
                end
            end
        end
    end
endmodule
